// File: rtl/request_unit.sv
// Memory-request sequencer for the single-cycle MIPS datapath: instruction fetch,
// held data requests until dhit, PC advance strobe, sticky halt, watchdog and stall count.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_FETCH | iREN high, waiting for ihit; decodes load/store/halt
// ST_DMEM  | dREN or dWEN held, waiting for dhit; watchdog running
// ST_HALT  | processor stopped, only RST leaves
module request_unit #(
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic             MemRead,
   input  logic             MemWr,
   input  logic             halt_req,
   output logic             iREN,
   output logic             dREN,
   output logic             dWEN,
   output logic             pc_en,
   output logic             halt,
   output logic             err,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam int WD_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_DMEM  = 2'd1,
      ST_HALT  = 2'd2
   } state_t;

   state_t          state;
   logic [WD_W-1:0] wd_cnt;
   logic            fetch_plain;
   logic            fetch_mem;

   assign fetch_mem   = ihit & ~halt_req & (MemRead | MemWr);
   assign fetch_plain = ihit & ~halt_req & ~MemRead & ~MemWr;

   // iREN and pc_en are the only outputs that see RST combinationally
   assign iREN  = ~RST & (state == ST_FETCH);
   assign pc_en = ~RST & (((state == ST_FETCH) & fetch_plain) |
                          ((state == ST_DMEM) & dhit));

   // Watchdog is a down-counter: loaded with TIMEOUT on DMEM entry, err on terminal count
   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= ST_FETCH;
         dREN      <= 1'b0;
         dWEN      <= 1'b0;
         halt      <= 1'b0;
         err       <= 1'b0;
         stall_cnt <= '0;
         wd_cnt    <= '0;
      end else begin
         if ((state != ST_HALT) && !pc_en && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + 1'b1;

         case (state)
            ST_FETCH: begin
               dREN <= 1'b0;
               dWEN <= 1'b0;
               if (ihit && halt_req) begin
                  state <= ST_HALT;
                  halt  <= 1'b1;
               end else if (fetch_mem) begin
                  state  <= ST_DMEM;
                  dWEN   <= MemWr;
                  dREN   <= MemRead & ~MemWr;
                  wd_cnt <= WD_W'(TIMEOUT);
               end
            end
            ST_DMEM: begin
               if (dhit) begin
                  state <= ST_FETCH;
                  dREN  <= 1'b0;
                  dWEN  <= 1'b0;
               end else if (wd_cnt != '0) begin
                  wd_cnt <= wd_cnt - 1'b1;
                  if (wd_cnt == WD_W'(1))
                     err <= 1'b1;
               end
            end
            ST_HALT: begin
               dREN <= 1'b0;
               dWEN <= 1'b0;
               halt <= 1'b1;
            end
            default: begin
               state <= ST_FETCH;
               dREN  <= 1'b0;
               dWEN  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_request_unit.sv
// Directed bench for request_unit: reset, plain fetch, load, read+write collision,
// watchdog timeout, halt priority and reset while a data request is outstanding.
module tb_request_unit;

   logic        CLK = 1'b0;
   logic        RST;
   logic        ihit, dhit, MemRead, MemWr, halt_req;
   logic        iREN, dREN, dWEN, pc_en, halt, err;
   logic [31:0] stall_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   request_unit #(.TIMEOUT(64), .CNT_W(32)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .ihit      (ihit),
      .dhit      (dhit),
      .MemRead   (MemRead),
      .MemWr     (MemWr),
      .halt_req  (halt_req),
      .iREN      (iREN),
      .dREN      (dREN),
      .dWEN      (dWEN),
      .pc_en     (pc_en),
      .halt      (halt),
      .err       (err),
      .stall_cnt (stall_cnt)
   );

   always #5 CLK = ~CLK;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Drive one cycle's inputs just after the falling edge; checks follow between edges
   task automatic cyc(input logic rst, input logic ih, input logic dh,
                      input logic mr, input logic mw, input logic hr);
      @(negedge CLK);
      RST = rst; ihit = ih; dhit = dh; MemRead = mr; MemWr = mw; halt_req = hr;
      #2;
   endtask

   initial begin
      RST = 1'b1; ihit = 1'b0; dhit = 1'b0; MemRead = 1'b0; MemWr = 1'b0; halt_req = 1'b0;

      // reset with ihit high
      cyc(1, 1, 0, 0, 0, 0);
      check_eq("rst_iren0", iREN, 0);
      check_eq("rst_pcen0", pc_en, 0);
      cyc(1, 1, 0, 0, 0, 0);
      check_eq("rst_iren", iREN, 0);
      check_eq("rst_pcen", pc_en, 0);
      check_eq("rst_dren", dREN, 0);
      check_eq("rst_dwen", dWEN, 0);
      check_eq("rst_halt", halt, 0);
      check_eq("rst_err", err, 0);
      check_eq("rst_stall", stall_cnt, 0);

      for (int i = 0; i < 3; i++) begin
         cyc(0, 1, 0, 0, 0, 0);
         check_eq("alu_iren", iREN, 1);
         check_eq("alu_pcen", pc_en, 1);
         check_eq("alu_stall", stall_cnt, 0);
      end

      // load: ihit at t, dhit at t+4
      cyc(0, 1, 0, 1, 0, 0);
      check_eq("ld_t_pcen", pc_en, 0);
      check_eq("ld_t_dren", dREN, 0);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 0, 0, 0, 0);
         check_eq("ld_wait_dren", dREN, 1);
         check_eq("ld_wait_dwen", dWEN, 0);
         check_eq("ld_wait_iren", iREN, 0);
         check_eq("ld_wait_pcen", pc_en, 0);
      end
      cyc(0, 0, 1, 0, 0, 0);
      check_eq("ld_hit_dren", dREN, 1);
      check_eq("ld_hit_pcen", pc_en, 1);
      cyc(0, 1, 0, 0, 0, 0);
      check_eq("ld_done_dren", dREN, 0);
      check_eq("ld_done_iren", iREN, 1);
      check_eq("ld_done_stall", stall_cnt, 4);

      // MemRead and MemWr together: write wins; ihit ignored in DMEM
      cyc(0, 1, 0, 1, 1, 0);
      check_eq("rw_t_pcen", pc_en, 0);
      cyc(0, 1, 0, 0, 0, 0);
      check_eq("rw_dwen", dWEN, 1);
      check_eq("rw_dren", dREN, 0);
      check_eq("rw_ihit_ignored", pc_en, 0);
      cyc(0, 0, 1, 0, 0, 0);
      check_eq("rw_hit_pcen", pc_en, 1);
      cyc(0, 1, 0, 0, 0, 0);
      check_eq("rw_done_dwen", dWEN, 0);
      check_eq("rw_done_dren", dREN, 0);
      check_eq("rw_done_iren", iREN, 1);
      check_eq("rw_done_stall", stall_cnt, 6);

      // store with watchdog timeout: err after the 64th waiting edge, dhit in cycle 70
      cyc(0, 1, 0, 0, 1, 0);
      for (int k = 1; k <= 69; k++) begin
         cyc(0, 0, 0, 0, 0, 0);
         if (k == 1)  check_eq("st_dwen", dWEN, 1);
         if (k == 64) check_eq("wd_err_before", err, 0);
         if (k == 65) check_eq("wd_err_set", err, 1);
         if (k == 69) check_eq("wd_still_wait", pc_en, 0);
      end
      cyc(0, 0, 1, 0, 0, 0);
      check_eq("wd_hit_pcen", pc_en, 1);
      check_eq("wd_hit_err", err, 1);
      cyc(0, 1, 0, 0, 0, 0);
      check_eq("wd_fetch_iren", iREN, 1);
      check_eq("wd_fetch_dwen", dWEN, 0);
      check_eq("wd_err_sticky", err, 1);
      check_eq("wd_stall", stall_cnt, 76);

      // halt_req beats MemWr; all inputs then ignored
      cyc(0, 1, 0, 0, 1, 1);
      check_eq("hlt_t_pcen", pc_en, 0);
      for (int i = 0; i < 10; i++) begin
         cyc(0, 1, 1, 1, 1, 1);
         check_eq("hlt_halt", halt, 1);
         check_eq("hlt_dwen", dWEN, 0);
         check_eq("hlt_iren", iREN, 0);
         check_eq("hlt_pcen", pc_en, 0);
         check_eq("hlt_stall", stall_cnt, 77);
      end
      cyc(1, 0, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0, 0);
      check_eq("hlt_rst_halt", halt, 0);
      check_eq("hlt_rst_err", err, 0);
      check_eq("hlt_rst_stall", stall_cnt, 0);
      check_eq("hlt_rst_pcen", pc_en, 1);

      // reset while a load is outstanding
      cyc(0, 1, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
      check_eq("ab_dren", dREN, 1);
      cyc(1, 0, 1, 0, 0, 0);
      check_eq("ab_rst_pcen", pc_en, 0);
      check_eq("ab_rst_iren", iREN, 0);
      cyc(0, 0, 0, 0, 0, 0);
      check_eq("ab_dren_clr", dREN, 0);
      check_eq("ab_fetch", iREN, 1);
      check_eq("ab_err", err, 0);
      check_eq("ab_stall", stall_cnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
